// File: rtl/fd_branch_ctrl.sv
// Fetch/decode pipeline register with zero-latency branch resolution,
// a {Z,V,N} flag register and a sticky halt state machine.
module fd_branch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] F_in,
  input  logic        stall,
  input  logic [2:0]  flags_we,
  input  logic [2:0]  flags_new,
  input  logic [15:0] rs_data,
  output logic [15:0] D_instr,
  output logic [15:0] D_pc_plus_2,
  output logic        D_valid,
  output logic        flush,
  output logic [15:0] branch_target,
  output logic        halt_PC
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t      state_q;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [2:0]  flags_q, flags_d;

  logic [3:0]  opcode;
  logic [2:0]  cond;
  logic        flag_z, flag_v, flag_n;
  logic        cond_true;
  logic        is_b, is_br, is_hlt;
  logic [15:0] b_offset;

  assign opcode = instr_q[15:12];
  assign cond   = instr_q[11:9];
  assign flag_z = flags_q[2];
  assign flag_v = flags_q[1];
  assign flag_n = flags_q[0];
  assign is_b   = (opcode == OP_B);
  assign is_br  = (opcode == OP_BR);
  assign is_hlt = (opcode == OP_HLT);

  // Word offset: sign-extended 9-bit immediate scaled to bytes.
  assign b_offset = {{6{instr_q[8]}}, instr_q[8:0], 1'b0};

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      3'b000: cond_true = !flag_z;
      3'b001: cond_true = flag_z;
      3'b010: cond_true = !flag_z && !flag_n;
      3'b011: cond_true = flag_n;
      3'b100: cond_true = flag_z || !flag_n;
      3'b101: cond_true = flag_n || flag_z;
      3'b110: cond_true = flag_v;
      3'b111: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    branch_target = pc_q;
    if (is_b)
      branch_target = pc_q + b_offset;
    else if (is_br)
      branch_target = rs_data;
  end

  assign flush   = valid_q && !stall && (is_b || is_br) && cond_true;
  assign halt_PC = (state_q == HALTED) || (valid_q && is_hlt);

  // A bubble carries pc_plus_2 along but an all-zero, invalid instruction,
  // which guarantees no flush or halt is raised from it.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (!stall) begin
      pc_d = F_in[31:16];
      if (flush || halt_PC) begin
        instr_d = 16'h0000;
        valid_d = 1'b0;
      end else begin
        instr_d = F_in[15:0];
        valid_d = 1'b1;
      end
    end
  end

  assign flags_d = (flags_q & ~flags_we) | (flags_new & flags_we);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      instr_q <= 16'h0000;
      pc_q    <= 16'h0000;
      valid_q <= 1'b0;
      flags_q <= 3'b000;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      flags_q <= flags_d;
      case (state_q)
        RUN:     if (valid_q && is_hlt && !stall) state_q <= HALTED;
        HALTED:  state_q <= HALTED;
        default: state_q <= RUN;
      endcase
    end
  end

  assign D_instr     = instr_q;
  assign D_pc_plus_2 = pc_q;
  assign D_valid     = valid_q;

endmodule

// File: tb/tb_fd_branch_ctrl.sv
// Table-driven directed bench for fd_branch_ctrl: each row drives one cycle's
// inputs and lists the outputs expected in that same cycle, before the edge.
module tb_fd_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] F_in = '0;
  logic        stall = 1'b0;
  logic [2:0]  flags_we = '0;
  logic [2:0]  flags_new = '0;
  logic [15:0] rs_data = '0;
  logic [15:0] D_instr, D_pc_plus_2, branch_target;
  logic        D_valid, flush, halt_PC;

  int checks = 0;
  int errors = 0;

  fd_branch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .F_in(F_in), .stall(stall),
    .flags_we(flags_we), .flags_new(flags_new), .rs_data(rs_data),
    .D_instr(D_instr), .D_pc_plus_2(D_pc_plus_2), .D_valid(D_valid),
    .flush(flush), .branch_target(branch_target), .halt_PC(halt_PC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [31:0] f_in;
    logic        stall;
    logic [2:0]  fwe;
    logic [2:0]  fnew;
    logic [15:0] rs;
    logic [15:0] e_instr;
    logic [15:0] e_pc;
    logic        e_valid;
    logic        e_flush;
    logic [15:0] e_bt;
    logic        e_halt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic [31:0] f, logic s, logic [2:0] we, logic [2:0] nw,
                              logic [15:0] rs, logic [15:0] ei, logic [15:0] ep, logic ev,
                              logic ef, logic [15:0] eb, logic eh);
    vec_t v;
    v.rst_n = r; v.f_in = f; v.stall = s; v.fwe = we; v.fnew = nw; v.rs = rs;
    v.e_instr = ei; v.e_pc = ep; v.e_valid = ev; v.e_flush = ef; v.e_bt = eb; v.e_halt = eh;
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [15:0] ei, logic [15:0] ep, logic ev,
                         logic ef, logic [15:0] eb, logic eh);
    chk({tag, " D_instr"}, D_instr, ei);
    chk({tag, " D_pc_plus_2"}, D_pc_plus_2, ep);
    chk({tag, " D_valid"}, {15'b0, D_valid}, {15'b0, ev});
    chk({tag, " flush"}, {15'b0, flush}, {15'b0, ef});
    chk({tag, " branch_target"}, branch_target, eb);
    chk({tag, " halt_PC"}, {15'b0, halt_PC}, {15'b0, eh});
  endtask

  initial begin
    //              rst f_in          stl we      new     rs       instr    pc       v  fl bt       h
    vq.push_back(mk(0, 32'h0004_A123, 0, 3'b000, 3'b000, 16'h0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0));
    vq.push_back(mk(1, 32'h0004_A123, 0, 3'b000, 3'b000, 16'h0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0));
    vq.push_back(mk(1, 32'h0010_C3FF, 0, 3'b100, 3'b100, 16'h0, 16'hA123, 16'h0004, 1, 0, 16'h0004, 0));
    vq.push_back(mk(1, 32'h0012_1111, 0, 3'b000, 3'b000, 16'h0, 16'hC3FF, 16'h0010, 1, 1, 16'h000E, 0));
    vq.push_back(mk(1, 32'h0020_C002, 0, 3'b000, 3'b000, 16'h0, 16'h0000, 16'h0012, 0, 0, 16'h0012, 0));
    vq.push_back(mk(1, 32'h0022_2222, 1, 3'b100, 3'b000, 16'h0, 16'hC002, 16'h0020, 1, 0, 16'h0024, 0));
    vq.push_back(mk(1, 32'h0022_2222, 1, 3'b000, 3'b000, 16'h0, 16'hC002, 16'h0020, 1, 0, 16'h0024, 0));
    vq.push_back(mk(1, 32'h0022_2222, 1, 3'b000, 3'b000, 16'h0, 16'hC002, 16'h0020, 1, 0, 16'h0024, 0));
    vq.push_back(mk(1, 32'h0030_5555, 0, 3'b000, 3'b000, 16'h0, 16'hC002, 16'h0020, 1, 1, 16'h0024, 0));
    vq.push_back(mk(1, 32'h0040_DE30, 0, 3'b000, 3'b000, 16'h1234, 16'h0000, 16'h0030, 0, 0, 16'h0030, 0));
    vq.push_back(mk(1, 32'h0042_7777, 0, 3'b000, 3'b000, 16'h1234, 16'hDE30, 16'h0040, 1, 1, 16'h1234, 0));
    vq.push_back(mk(1, 32'h0050_F000, 0, 3'b000, 3'b000, 16'h1234, 16'h0000, 16'h0042, 0, 0, 16'h0042, 0));
    vq.push_back(mk(1, 32'h0052_8888, 1, 3'b000, 3'b000, 16'h0, 16'hF000, 16'h0050, 1, 0, 16'h0050, 1));
    vq.push_back(mk(1, 32'h0052_8888, 0, 3'b000, 3'b000, 16'h0, 16'hF000, 16'h0050, 1, 0, 16'h0050, 1));
    vq.push_back(mk(1, 32'h0060_A123, 0, 3'b000, 3'b000, 16'h0, 16'h0000, 16'h0052, 0, 0, 16'h0052, 1));
    vq.push_back(mk(1, 32'h0070_C3FF, 0, 3'b000, 3'b000, 16'h0, 16'h0000, 16'h0060, 0, 0, 16'h0060, 1));
    vq.push_back(mk(0, 32'h0070_C3FF, 0, 3'b000, 3'b000, 16'h0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0));
    vq.push_back(mk(1, 32'h0080_C600, 0, 3'b101, 3'b111, 16'h0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0));
    vq.push_back(mk(1, 32'h0082_CC00, 0, 3'b000, 3'b000, 16'h0, 16'hC600, 16'h0080, 1, 1, 16'h0080, 0));
    vq.push_back(mk(1, 32'h0090_CC00, 0, 3'b000, 3'b000, 16'h0, 16'h0000, 16'h0082, 0, 0, 16'h0082, 0));
    vq.push_back(mk(1, 32'h0092_0000, 0, 3'b000, 3'b000, 16'h0, 16'hCC00, 16'h0090, 1, 0, 16'h0090, 0));
    vq.push_back(mk(1, 32'h00A0_0000, 0, 3'b000, 3'b000, 16'h0, 16'h0000, 16'h0092, 1, 0, 16'h0092, 0));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst_n     = vq[i].rst_n;
      F_in      = vq[i].f_in;
      stall     = vq[i].stall;
      flags_we  = vq[i].fwe;
      flags_new = vq[i].fnew;
      rs_data   = vq[i].rs;
      #1;
      chk_all($sformatf("vec%0d", i), vq[i].e_instr, vq[i].e_pc, vq[i].e_valid,
              vq[i].e_flush, vq[i].e_bt, vq[i].e_halt);
      $display("vec %0d: rst_n=%b F_in=%h stall=%b D_instr=%h D_pc=%h D_valid=%b flush=%b target=%h halt_PC=%b",
               i, rst_n, F_in, stall, D_instr, D_pc_plus_2, D_valid, flush, branch_target, halt_PC);
    end

    // Short reset pulse entirely between two edges; flags must be cleared too.
    @(negedge clk);
    F_in = 32'h00B0_C3FF;
    stall = 1'b0;
    flags_we = 3'b000;
    #1 rst_n = 1'b0;
    #1;
    chk_all("async_pulse", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    $display("async pulse: D_instr=%h D_pc=%h D_valid=%b halt_PC=%b", D_instr, D_pc_plus_2, D_valid, halt_PC);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_all("post_pulse", 16'hC3FF, 16'h00B0, 1'b1, 1'b0, 16'h00AE, 1'b0);
    $display("post pulse: D_instr=%h D_pc=%h flush=%b target=%h", D_instr, D_pc_plus_2, flush, branch_target);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
